scalar_wb_arbiter: RTL and testbench
====================================

Name: scalar_wb_arbiter

Overview:
- Shares the single write port of the scalar register file (15 x 32-bit, 5-bit address) between two writeback sources: the ALU (port A) and the load/memory unit (port B).
- Round-robin arbitration; drives the file's write-enable, destination and data from registered outputs.
- Holds a per-register pending-write scoreboard that the issue stage sets and the arbiter clears on commit, so decode can stall on RAW hazards.

Parameters:
NREGS, 15, number of scalar registers tracked/writable (valid rd range 0..NREGS-1)
AW, 5, register address width
DW, 32, data width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
hold  input  1  when 1, no grants issued this cycle
a_valid  input  1  ALU writeback request
a_ready  output  1  ALU request accepted this cycle
a_rd  input  AW  ALU destination register
a_data  input  DW  ALU result
b_valid  input  1  load-unit writeback request
b_ready  output  1  load request accepted this cycle
b_rd  input  AW  load destination register
b_data  input  DW  load data
iss_valid  input  1  issue stage marks a register as pending
iss_rd  input  AW  register being marked
q_rs1  input  AW  hazard query address 1
q_rs2  input  AW  hazard query address 2
q_busy1  output  1  pending bit for q_rs1
q_busy2  output  1  pending bit for q_rs2
rf_we  output  1  to register file WriteEn
rf_rd  output  AW  to register file rd
rf_data  output  DW  to register file InputData

Behaviour:
- Reset (rst_n low, async): rf_we=0, rf_rd=0, rf_data=0, all pending bits=0, last_grant=B (so A wins the first contention). a_ready/b_ready=0 while in reset.
- Handshake: transfer when x_valid && x_ready. Ready is combinational from the valids, hold and last_grant; it must not depend on a ready output. Requester holds valid/rd/data stable until accepted.
- Grant, when hold=0:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the source not equal to last_grant.
  - At most one of a_ready/b_ready is high in any cycle.
- hold=1: both ready=0 and last_grant is unchanged.
- last_grant updates to the granted source on every grant.
- Write latency is 1 cycle. On the edge after a grant: rf_we=1, rf_rd=granted rd, rf_data=granted data. Otherwise rf_we=0; rf_rd/rf_data hold their last values.
- Out-of-range rd (>= NREGS): the request is still accepted (ready=1) and consumes the grant and round-robin slot. It is not written: rf_we stays 0 and the scoreboard is untouched.
- Scoreboard: one bit per register, held in pending[NREGS-1:0].
  - Set on the edge when iss_valid=1 and iss_rd < NREGS.
  - Cleared on the edge when rf_we=1 (the cycle the file actually writes), for bit rf_rd.
  - Set and clear of the same register in the same cycle: set wins (the new producer is outstanding).
  - iss_rd out of range: ignored.
- Queries are combinational: q_busyN = pending[q_rsN] for q_rsN < NREGS, else 0. No bypass: a register being cleared this cycle still reads busy until the next edge.
- Register 0 has no special treatment.
- Reset mid-operation: an in-flight registered write is dropped (rf_we forced 0) and pending bits are cleared. Upstream must re-issue.

Test Plan:
- Reset then a_valid=1, a_rd=3, a_data=0x1234_5678 for one cycle -> a_ready=1 same cycle; next cycle rf_we=1, rf_rd=3, rf_data=0x12345678; cycle after, rf_we=0.
- a_valid and b_valid both held high with 4 distinct requests each (A rd=1..4, B rd=5..8) -> grants alternate A,B,A,B..., first grant A; 8 consecutive rf_we pulses in order 1,5,2,6,3,7,4,8.
- hold=1 for 3 cycles with both valid -> no ready, rf_we=0; hold drops -> grant follows the last_grant from before hold.
- iss_valid rd=7, then q_rs1=7 -> q_busy1=1. B writes rd=7: q_busy1 stays 1 while rf_we=1 and goes 0 the following cycle. In the same cycle, iss_valid rd=7 alongside the rf_we commit -> bit stays 1.
- a_rd=15 (out of range), a_data=0xFFFF_FFFF -> a_ready=1, no rf_we pulse. iss_rd=15 -> q_busy for 15 reads 0.
- Assert rst_n=0 in the cycle after a grant -> rf_we=0 immediately (async), all q_busy=0. After release, next contention grants A first.

Source files
------------

// File: rtl/scalar_wb_arbiter.sv
// Round-robin arbiter sharing the scalar register file write port between
// the ALU (port A) and the load unit (port B). Also keeps a per-register
// pending-write scoreboard that issue sets and commit clears, so decode can
// stall on RAW hazards.
module scalar_wb_arbiter #(
  parameter int NREGS = 15,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_data,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] q_rs1,
  input  logic [AW-1:0] q_rs2,
  output logic          q_busy1,
  output logic          q_busy2,
  output logic          rf_we,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_data
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  localparam logic [AW-1:0] NREGS_L = AW'(NREGS);

  src_e             last_grant;
  src_e             last_grant_next;
  logic             grant_a;
  logic             grant_b;
  logic             a_in_range;
  logic             b_in_range;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;

  assign a_in_range = (a_rd < NREGS_L);
  assign b_in_range = (b_rd < NREGS_L);
  assign a_ready    = grant_a;
  assign b_ready    = grant_b;

  // Grant selection: a lone requester wins; on contention the source that
  // did not win last time gets the port. Nothing is granted under hold or reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_a         = 1'b0;
    grant_b         = 1'b0;
    last_grant_next = last_grant;
    if (rst_n && !hold) begin
      if (a_valid && (!b_valid || last_grant == SRC_B)) begin
        grant_a         = 1'b1;
        last_grant_next = SRC_A;
      end else if (b_valid) begin
        grant_b         = 1'b1;
        last_grant_next = SRC_B;
      end
    end
  end

  // Round-robin pointer; starts at B so A wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      last_grant <= SRC_B;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  // Registered write port: one-cycle pulse per in-range grant; rd/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= 1'b0;
      if (grant_a && a_in_range) begin
        rf_we   <= 1'b1;
        rf_rd   <= a_rd;
        rf_data <= a_data;
      end else if (grant_b && b_in_range) begin
        rf_we   <= 1'b1;
        rf_rd   <= b_rd;
        rf_data <= b_data;
      end
    end
  end

  // Scoreboard next state: commit clears, issue sets, and set is applied last
  // so a new producer for the register being committed stays outstanding.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < NREGS; i++) begin
      if (rf_we && rf_rd == AW'(i)) pending_next[i] = 1'b0;
      if (iss_valid && iss_rd == AW'(i)) pending_next[i] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this is a small flop vector, not a RAM, so resetting every bit is cheap and required.
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Hazard queries read the current bits; out-of-range addresses are never busy.
  always_comb begin
    q_busy1 = 1'b0;
    q_busy2 = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (q_rs1 == AW'(i)) q_busy1 = pending[i];
      if (q_rs2 == AW'(i)) q_busy2 = pending[i];
    end
  end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed testbench for scalar_wb_arbiter. Inputs change 1 time unit after
// a rising edge; combinational outputs are sampled 1 unit after that and
// registered outputs 1 unit after the next rising edge.
module tb_scalar_wb_arbiter;

  localparam int NREGS = 15;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk;
  logic          rst_n;
  logic          hold;
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_rd;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_rd;
  logic [DW-1:0] b_data;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic [AW-1:0] q_rs1;
  logic [AW-1:0] q_rs2;
  logic          q_busy1;
  logic          q_busy2;
  logic          rf_we;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_data;

  int total = 0;
  int bad   = 0;

  scalar_wb_arbiter #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_rd     (a_rd),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_rd     (b_rd),
    .b_data   (b_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .q_busy1  (q_busy1),
    .q_busy2  (q_busy2),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_data  (rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hold      = 1'b0;
    a_valid   = 1'b0;
    a_rd      = '0;
    a_data    = '0;
    b_valid   = 1'b0;
    b_rd      = '0;
    b_data    = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    q_rs1   = 5'd0;
    q_rs2   = 5'd7;
    rst_n   = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    tick();
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_b_ready got=%b exp=0", b_ready); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    total++; if (rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rf_rd got=%0d exp=0", rf_rd); end
    total++; if (rf_data !== 32'd0) begin bad++; $display("FAIL reset_rf_data got=%h exp=0", rf_data); end
    total++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b exp=00", q_busy1, q_busy2); end
    idle_inputs();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_write();
    a_valid = 1'b1;
    a_rd    = 5'd3;
    a_data  = 32'h1234_5678;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL single_a_ready got=%b exp=1", a_ready); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL single_b_ready got=%b exp=0", b_ready); end
    tick();
    a_valid = 1'b0;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", rf_we); end
    total++; if (rf_rd !== 5'd3) begin bad++; $display("FAIL single_rd got=%0d exp=3", rf_rd); end
    total++; if (rf_data !== 32'h1234_5678) begin bad++; $display("FAIL single_data got=%h exp=12345678", rf_data); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_we_drop got=%b exp=0", rf_we); end
    total++; if (rf_rd !== 5'd3) begin bad++; $display("FAIL single_rd_hold got=%0d exp=3", rf_rd); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_rd [8] = '{5'd1, 5'd5, 5'd2, 5'd6, 5'd3, 5'd7, 5'd4, 5'd8};
    logic [DW-1:0] exp_data;
    int ai = 0;
    int bi = 0;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      a_valid = (ai < 4);
      a_rd    = AW'(ai + 1);
      a_data  = 32'hA000_0000 | DW'(ai + 1);
      b_valid = (bi < 4);
      b_rd    = AW'(bi + 5);
      b_data  = 32'hB000_0000 | DW'(bi + 5);
      #1;
      total++; if (a_ready !== (k % 2 == 0)) begin bad++; $display("FAIL rr_a_ready k=%0d got=%b exp=%b", k, a_ready, (k % 2 == 0)); end
      total++; if (b_ready !== (k % 2 == 1)) begin bad++; $display("FAIL rr_b_ready k=%0d got=%b exp=%b", k, b_ready, (k % 2 == 1)); end
      tick();
      if (k % 2 == 0) ai++; else bi++;
      exp_data = (k % 2 == 0) ? (32'hA000_0000 | DW'(exp_rd[k])) : (32'hB000_0000 | DW'(exp_rd[k]));
      total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL rr_we k=%0d got=%b exp=1", k, rf_we); end
      total++; if (rf_rd !== exp_rd[k]) begin bad++; $display("FAIL rr_rd k=%0d got=%0d exp=%0d", k, rf_rd, exp_rd[k]); end
      total++; if (rf_data !== exp_data) begin bad++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, rf_data, exp_data); end
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    // Last grant before this test went to B, so A must win after hold drops.
    hold    = 1'b1;
    a_valid = 1'b1;
    a_rd    = 5'd9;
    a_data  = 32'h0000_0009;
    b_valid = 1'b1;
    b_rd    = 5'd10;
    b_data  = 32'h0000_000A;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL hold_ready k=%0d got=%b%b exp=00", k, a_ready, b_ready); end
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL hold_we k=%0d got=%b exp=0", k, rf_we); end
    end
    hold = 1'b0;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL hold_release got=%b%b exp=10", a_ready, b_ready); end
    tick();
    a_valid = 1'b0;
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd9) begin bad++; $display("FAIL hold_write_a got=%b/%0d exp=1/9", rf_we, rf_rd); end
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL hold_b_after got=%b exp=1", b_ready); end
    tick();
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd10) begin bad++; $display("FAIL hold_write_b got=%b/%0d exp=1/10", rf_we, rf_rd); end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    q_rs1     = 5'd7;
    q_rs2     = 5'd6;
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    #1;
    total++; if (q_busy1 !== 1'b0) begin bad++; $display("FAIL sb_before_set got=%b exp=0", q_busy1); end
    tick();
    iss_valid = 1'b0;
    total++; if (q_busy1 !== 1'b1) begin bad++; $display("FAIL sb_set got=%b exp=1", q_busy1); end
    total++; if (q_busy2 !== 1'b0) begin bad++; $display("FAIL sb_other got=%b exp=0", q_busy2); end
    b_valid = 1'b1;
    b_rd    = 5'd7;
    b_data  = 32'h0000_0077;
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL sb_b_ready got=%b exp=1", b_ready); end
    tick();
    b_valid = 1'b0;
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7) begin bad++; $display("FAIL sb_commit got=%b/%0d exp=1/7", rf_we, rf_rd); end
    total++; if (q_busy1 !== 1'b1) begin bad++; $display("FAIL sb_no_bypass got=%b exp=1", q_busy1); end
    tick();
    total++; if (q_busy1 !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%b exp=0", q_busy1); end
    // Re-issue 7, then commit it while issuing 7 again in the same cycle.
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    b_valid   = 1'b1;
    tick();
    b_valid   = 1'b0;
    iss_valid = 1'b1;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL sb_commit2 got=%b exp=1", rf_we); end
    tick();
    iss_valid = 1'b0;
    total++; if (q_busy1 !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%b exp=1", q_busy1); end
    tick();
    total++; if (q_busy1 !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("FAIL sb_set_stays got=%b/%b exp=1/0", q_busy1, rf_we); end
  endtask

  task automatic test_out_of_range();
    // Last grant was B; an out-of-range A request still takes the slot.
    a_valid = 1'b1;
    a_rd    = 5'd15;
    a_data  = 32'hFFFF_FFFF;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL oor_a_ready got=%b exp=1", a_ready); end
    tick();
    a_valid = 1'b0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL oor_no_we got=%b exp=0", rf_we); end
    total++; if (rf_rd !== 5'd7 || rf_data !== 32'h0000_0077) begin bad++; $display("FAIL oor_hold got=%0d/%h exp=7/00000077", rf_rd, rf_data); end
    iss_valid = 1'b1;
    iss_rd    = 5'd15;
    q_rs2     = 5'd15;
    tick();
    total++; if (q_busy2 !== 1'b0) begin bad++; $display("FAIL oor_busy15 got=%b exp=0", q_busy2); end
    iss_rd = 5'd14;
    q_rs1  = 5'd14;
    tick();
    iss_valid = 1'b0;
    total++; if (q_busy1 !== 1'b1) begin bad++; $display("FAIL oor_busy14 got=%b exp=1", q_busy1); end
    // The out-of-range grant went to A, so B wins this contention.
    a_valid = 1'b1;
    a_rd    = 5'd1;
    b_valid = 1'b1;
    b_rd    = 5'd2;
    b_data  = 32'h0000_0222;
    #1;
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin bad++; $display("FAIL oor_rr got=%b%b exp=01", a_ready, b_ready); end
    tick();
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd2) begin bad++; $display("FAIL oor_rr_write got=%b/%0d exp=1/2", rf_we, rf_rd); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    q_rs1 = 5'd14;
    q_rs2 = 5'd7;
    #1;
    total++; if (q_busy1 !== 1'b1 || q_busy2 !== 1'b1) begin bad++; $display("FAIL mid_pre_busy got=%b%b exp=11", q_busy1, q_busy2); end
    a_valid = 1'b1;
    a_rd    = 5'd4;
    a_data  = 32'h0000_0044;
    tick();
    a_valid = 1'b0;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL mid_inflight got=%b exp=1", rf_we); end
    rst_n = 1'b0;
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_async_we got=%b exp=0", rf_we); end
    total++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b%b exp=00", q_busy1, q_busy2); end
    tick();
    rst_n   = 1'b1;
    a_valid = 1'b1;
    a_rd    = 5'd1;
    b_valid = 1'b1;
    b_rd    = 5'd2;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL mid_first_a got=%b%b exp=10", a_ready, b_ready); end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    q_rs1 = '0;
    q_rs2 = '0;
    #2;
    test_reset();
    test_single_write();
    test_round_robin();
    test_hold();
    test_scoreboard();
    test_out_of_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
